// File: rtl/mult_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : mult_pkg
//  Description : Shared definitions for the round-robin multiplier scheduler.
//                State encoding, default operand width / timeout limit and
//                the product-width helper.
//  Revision    : 1.0 - initial release
// ============================================================================
package mult_pkg;

    localparam int C_DEF_WIDTH   = 32;
    localparam int C_DEF_MAX_LAT = 40;
    localparam int C_DEF_PROD_W  = 2 * C_DEF_WIDTH;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        GAP  = 2'd2
    } state_t;

    // Full signed product of two width-bit operands.
    function automatic int prod_width(input int width);
        return 2 * width;
    endfunction

endpackage
`default_nettype wire

// File: rtl/mult_rr_sched_if.sv
`default_nettype none
// ============================================================================
//  Module      : mult_rr_sched_if
//  Description : Requester-side bus of the multiplier scheduler.
//                req/req_a/req_b : request level and per-requester operands
//                gnt             : one-hot accept pulse
//                rsp_*           : one-hot response pulse plus product,
//                                  latency and timeout flag
//                slave  modport  : scheduler side
//                master modport  : requester side
//  Revision    : 1.0 - initial release
// ============================================================================
interface mult_rr_sched_if
    import mult_pkg::*;
#(
    parameter int N_REQ = 4,
    parameter int WIDTH = C_DEF_WIDTH,
    parameter int CNT_W = 6
);

    logic [N_REQ-1:0]       req;
    logic [N_REQ*WIDTH-1:0] req_a;
    logic [N_REQ*WIDTH-1:0] req_b;
    logic [N_REQ-1:0]       gnt;
    logic [N_REQ-1:0]       rsp_valid;
    logic [2*WIDTH-1:0]     rsp_prod;
    logic [CNT_W-1:0]       rsp_lat;
    logic                   rsp_timeout;

    modport slave (
        input  req, req_a, req_b,
        output gnt, rsp_valid, rsp_prod, rsp_lat, rsp_timeout
    );

    modport master (
        output req, req_a, req_b,
        input  gnt, rsp_valid, rsp_prod, rsp_lat, rsp_timeout
    );

endinterface
`default_nettype wire

// File: rtl/rr_pick.sv
`default_nettype none
// ============================================================================
//  Module      : rr_pick
//  Description : Combinational round-robin select. Finds the first set bit of
//                req at or after ptr, wrapping at N_REQ.
//                req   : request vector
//                ptr   : highest-priority position (must be < N_REQ)
//                grant : one-hot winner
//                idx   : binary index of the winner
//                any   : at least one request present
//  Revision    : 1.0 - initial release
// ============================================================================
module rr_pick #(
    parameter int N_REQ = 4,
    parameter int PTR_W = 2
) (
    input  logic [N_REQ-1:0] req,
    input  logic [PTR_W-1:0] ptr,
    output logic [N_REQ-1:0] grant,
    output logic [PTR_W-1:0] idx,
    output logic             any
);

    localparam int SUM_W = PTR_W + 1;

    // ptr < N_REQ and offset < N_REQ, so one subtraction is enough to wrap.
    logic [SUM_W-1:0] w_sum;
    logic [PTR_W-1:0] w_pos;

    always_comb begin
        grant = '0;
        idx   = '0;
        any   = 1'b0;
        w_sum = '0;
        w_pos = '0;
        for (int i = 0; i < N_REQ; i++) begin
            w_sum = {1'b0, ptr} + SUM_W'(i);
            if (w_sum >= SUM_W'(N_REQ)) begin
                w_sum = w_sum - SUM_W'(N_REQ);
            end
            w_pos = w_sum[PTR_W-1:0];
            if (!any && req[w_pos]) begin
                any          = 1'b1;
                grant[w_pos] = 1'b1;
                idx          = w_pos;
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/mult_rr_sched.sv
`default_nettype none
// ============================================================================
//  Module      : mult_rr_sched
//  Description : Round-robin scheduler sharing one variable-latency multiplier
//                between N_REQ requesters. Grants one request, holds start and
//                operands until the multiplier reports valid (or MAX_LAT BUSY
//                cycles elapse), returns product/latency/timeout to the owner,
//                then inserts one GAP cycle so start always re-rises.
//                clock/reset : clock, asynchronous active-high reset
//                bus         : requester bus (slave side)
//                busy        : high in BUSY and GAP
//                m_*         : multiplier start/operands out, product/valid in
//  Revision    : 1.0 - initial release
// ============================================================================
module mult_rr_sched
    import mult_pkg::*;
#(
    parameter int N_REQ   = 4,
    parameter int WIDTH   = C_DEF_WIDTH,
    parameter int MAX_LAT = C_DEF_MAX_LAT,
    parameter int CNT_W   = 6
) (
    input  wire logic                      clock,
    input  wire logic                      reset,
    mult_rr_sched_if.slave                 bus,
    output logic                           busy,
    output logic                           m_start,
    output logic [WIDTH-1:0]               m_mlier,
    output logic [WIDTH-1:0]               m_mcand,
    input  wire logic [prod_width(WIDTH)-1:0] m_prodt,
    input  wire logic                      m_valid
);

    localparam int PTR_W  = $clog2(N_REQ);
    localparam int PROD_W = prod_width(WIDTH);

    state_t             r_state, w_state;
    logic [PTR_W-1:0]   r_ptr, w_ptr;
    logic [PTR_W-1:0]   r_owner, w_owner;
    logic [CNT_W-1:0]   r_lat, w_lat;
    logic [N_REQ-1:0]   r_gnt, w_gnt;
    logic [N_REQ-1:0]   r_rsp_valid, w_rsp_valid;
    logic [PROD_W-1:0]  r_rsp_prod, w_rsp_prod;
    logic [CNT_W-1:0]   r_rsp_lat, w_rsp_lat;
    logic               r_rsp_timeout, w_rsp_timeout;
    logic               r_busy, w_busy;
    logic               r_m_start, w_m_start;
    logic [WIDTH-1:0]   r_m_mlier, w_m_mlier;
    logic [WIDTH-1:0]   r_m_mcand, w_m_mcand;

    logic [N_REQ-1:0]   w_pick_oh;
    logic [PTR_W-1:0]   w_pick_idx;
    logic               w_pick_any;

    rr_pick #(
        .N_REQ (N_REQ),
        .PTR_W (PTR_W)
    ) u_rr_pick (
        .req   (bus.req),
        .ptr   (r_ptr),
        .grant (w_pick_oh),
        .idx   (w_pick_idx),
        .any   (w_pick_any)
    );

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_state       <= IDLE;
            r_ptr         <= '0;
            r_owner       <= '0;
            r_lat         <= '0;
            r_gnt         <= '0;
            r_rsp_valid   <= '0;
            r_rsp_prod    <= '0;
            r_rsp_lat     <= '0;
            r_rsp_timeout <= 1'b0;
            r_busy        <= 1'b0;
            r_m_start     <= 1'b0;
            r_m_mlier     <= '0;
            r_m_mcand     <= '0;
        end else begin
            r_state       <= w_state;
            r_ptr         <= w_ptr;
            r_owner       <= w_owner;
            r_lat         <= w_lat;
            r_gnt         <= w_gnt;
            r_rsp_valid   <= w_rsp_valid;
            r_rsp_prod    <= w_rsp_prod;
            r_rsp_lat     <= w_rsp_lat;
            r_rsp_timeout <= w_rsp_timeout;
            r_busy        <= w_busy;
            r_m_start     <= w_m_start;
            r_m_mlier     <= w_m_mlier;
            r_m_mcand     <= w_m_mcand;
        end
    end

    always_comb begin
        w_state       = r_state;
        w_ptr         = r_ptr;
        w_owner       = r_owner;
        w_lat         = r_lat;
        w_gnt         = '0;
        w_rsp_valid   = '0;
        w_rsp_prod    = r_rsp_prod;
        w_rsp_lat     = r_rsp_lat;
        w_rsp_timeout = r_rsp_timeout;
        w_busy        = r_busy;
        w_m_start     = r_m_start;
        w_m_mlier     = r_m_mlier;
        w_m_mcand     = r_m_mcand;

        case (r_state)
            IDLE: begin
                if (w_pick_any) begin
                    w_gnt     = w_pick_oh;
                    w_owner   = w_pick_idx;
                    // Operands are captured only on the grant edge.
                    for (int i = 0; i < N_REQ; i++) begin
                        if (w_pick_oh[i]) begin
                            w_m_mlier = bus.req_a[i*WIDTH +: WIDTH];
                            w_m_mcand = bus.req_b[i*WIDTH +: WIDTH];
                        end
                    end
                    w_m_start = 1'b1;
                    w_busy    = 1'b1;
                    w_lat     = CNT_W'(1);
                    w_state   = BUSY;
                end
            end

            BUSY: begin
                // A valid on the limit edge still counts as a real result.
                if (m_valid || (r_lat == CNT_W'(MAX_LAT))) begin
                    w_rsp_prod           = m_valid ? m_prodt : '0;
                    w_rsp_lat            = r_lat;
                    w_rsp_timeout        = !m_valid;
                    w_rsp_valid[r_owner] = 1'b1;
                    w_m_start            = 1'b0;
                    w_ptr                = (r_owner == PTR_W'(N_REQ - 1)) ? '0
                                                                          : r_owner + PTR_W'(1);
                    w_state              = GAP;
                end else begin
                    w_lat = r_lat + CNT_W'(1);
                end
            end

            GAP: begin
                w_busy  = 1'b0;
                w_state = IDLE;
            end

            default: begin
                w_busy    = 1'b0;
                w_m_start = 1'b0;
                w_state   = IDLE;
            end
        endcase
    end

    assign bus.gnt         = r_gnt;
    assign bus.rsp_valid   = r_rsp_valid;
    assign bus.rsp_prod    = r_rsp_prod;
    assign bus.rsp_lat     = r_rsp_lat;
    assign bus.rsp_timeout = r_rsp_timeout;
    assign busy            = r_busy;
    assign m_start         = r_m_start;
    assign m_mlier         = r_m_mlier;
    assign m_mcand         = r_m_mcand;

endmodule
`default_nettype wire

// File: tb/tb_mult_rr_sched.sv
`default_nettype none
// ============================================================================
//  Module      : tb_mult_rr_sched
//  Description : Directed self-checking bench for mult_rr_sched with a small
//                behavioural multiplier whose valid latency is programmable
//                (mdl_lat = BUSY edge on which valid is seen, 0 = never).
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_mult_rr_sched;

    logic        clock;
    logic        reset;
    logic        busy;
    logic        m_start;
    logic [31:0] m_mlier;
    logic [31:0] m_mcand;
    logic [63:0] m_prodt;
    logic        m_valid;

    int checks = 0;
    int errors = 0;
    int mdl_lat = 0;
    int mcnt;

    mult_rr_sched_if #(.N_REQ(4), .WIDTH(32), .CNT_W(6)) bus ();

    mult_rr_sched #(
        .N_REQ   (4),
        .WIDTH   (32),
        .MAX_LAT (40),
        .CNT_W   (6)
    ) dut (
        .clock   (clock),
        .reset   (reset),
        .bus     (bus),
        .busy    (busy),
        .m_start (m_start),
        .m_mlier (m_mlier),
        .m_mcand (m_mcand),
        .m_prodt (m_prodt),
        .m_valid (m_valid)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Behavioural multiplier: counts edges since start rose.
    always @(posedge clock or posedge reset) begin
        if (reset)         mcnt <= 0;
        else if (!m_start) mcnt <= 0;
        else               mcnt <= mcnt + 1;
    end
    assign m_valid = m_start && (mdl_lat != 0) && (mcnt >= mdl_lat - 1);
    assign m_prodt = {{32{m_mlier[31]}}, m_mlier} * {{32{m_mcand[31]}}, m_mcand};

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic chk_zero(input string tag);
        chk($sformatf("%s_gnt", tag),     64'(bus.gnt),         64'd0);
        chk($sformatf("%s_rspv", tag),    64'(bus.rsp_valid),   64'd0);
        chk($sformatf("%s_prod", tag),    bus.rsp_prod,         64'd0);
        chk($sformatf("%s_lat", tag),     64'(bus.rsp_lat),     64'd0);
        chk($sformatf("%s_tmo", tag),     64'(bus.rsp_timeout), 64'd0);
        chk($sformatf("%s_busy", tag),    64'(busy),            64'd0);
        chk($sformatf("%s_mstart", tag),  64'(m_start),         64'd0);
        chk($sformatf("%s_mlier", tag),   64'(m_mlier),         64'd0);
        chk($sformatf("%s_mcand", tag),   64'(m_mcand),         64'd0);
    endtask

    task automatic wait_gnt(output logic [3:0] g);
        g = '0;
        for (int n = 0; n < 200; n++) begin
            @(negedge clock);
            if (bus.gnt !== 4'b0) begin
                g = bus.gnt;
                break;
            end
        end
    endtask

    task automatic wait_rsp(output logic [3:0] r);
        r = '0;
        for (int n = 0; n < 200; n++) begin
            @(negedge clock);
            if (bus.rsp_valid !== 4'b0) begin
                r = bus.rsp_valid;
                break;
            end
        end
    endtask

    task automatic run_op(input int idx, input logic [31:0] a, input logic [31:0] b,
                          input int lat, input string tag, input logic [63:0] exp_prod,
                          input logic [5:0] exp_lat, input logic exp_tmo);
        logic [3:0] g;
        logic [3:0] r;
        logic [3:0] onehot;
        onehot = 4'b0001 << idx;
        mdl_lat = lat;
        bus.req_a[idx*32 +: 32] = a;
        bus.req_b[idx*32 +: 32] = b;
        bus.req[idx] = 1'b1;
        wait_gnt(g);
        chk($sformatf("%s_gnt", tag), 64'(g), 64'(onehot));
        chk($sformatf("%s_mstart_hi", tag), 64'(m_start), 64'd1);
        chk($sformatf("%s_busy", tag), 64'(busy), 64'd1);
        bus.req[idx] = 1'b0;
        @(negedge clock);
        chk($sformatf("%s_gnt_once", tag), 64'(bus.gnt), 64'd0);
        r = bus.rsp_valid;
        if (r == 4'b0) wait_rsp(r);
        chk($sformatf("%s_rspv", tag), 64'(r), 64'(onehot));
        chk($sformatf("%s_prod", tag), bus.rsp_prod, exp_prod);
        chk($sformatf("%s_lat", tag), 64'(bus.rsp_lat), 64'(exp_lat));
        chk($sformatf("%s_tmo", tag), 64'(bus.rsp_timeout), 64'(exp_tmo));
        chk($sformatf("%s_mstart_lo", tag), 64'(m_start), 64'd0);
    endtask

    initial begin
        logic [3:0] g;
        logic [3:0] r;
        int low;

        bus.req   = '0;
        bus.req_a = '0;
        bus.req_b = '0;
        reset     = 1'b1;

        // Reset state.
        @(negedge clock);
        chk_zero("reset");
        @(negedge clock);
        reset = 1'b0;

        // Single request, 3*5, valid on BUSY edge 5.
        run_op(1, 32'd3, 32'd5, 5, "single", 64'h0F, 6'd5, 1'b0);
        repeat (3) @(negedge clock);
        chk("hold_prod", bus.rsp_prod, 64'h0F);
        chk("hold_lat", 64'(bus.rsp_lat), 64'd5);

        // Signed products, including the slowest normal latency.
        run_op(0, 32'hFFFF_FFFE, 32'd7, 33, "neg", 64'hFFFF_FFFF_FFFF_FFF2, 6'd33, 1'b0);
        run_op(0, 32'h0FFF_FFFE, 32'h0FFF_FFFE, 1, "big", 64'h00FF_FFFF_C000_0004, 6'd1, 1'b0);

        // Timeout, then a normal operation.
        run_op(2, 32'd9, 32'd9, 0, "tmo", 64'd0, 6'd40, 1'b1);
        run_op(3, 32'd6, 32'd7, 3, "after_tmo", 64'h2A, 6'd3, 1'b0);

        // Valid arrives on the same edge the limit is reached.
        run_op(1, 32'd100, 32'hFFFF_FFFD, 40, "collide", 64'hFFFF_FFFF_FFFF_FED4, 6'd40, 1'b0);

        // Reset in the middle of an operation (pointer is 2 here).
        mdl_lat = 0;
        bus.req_a[64 +: 32] = 32'd11;
        bus.req_b[64 +: 32] = 32'd12;
        bus.req[2] = 1'b1;
        wait_gnt(g);
        chk("mid_gnt", 64'(g), 64'b0100);
        bus.req[2] = 1'b0;
        repeat (9) @(posedge clock);
        #2 reset = 1'b1;
        #1 chk_zero("mid_rst");
        @(negedge clock);
        mdl_lat = 4;
        bus.req_a[32 +: 32] = 32'd2;
        bus.req_b[32 +: 32] = 32'd3;
        bus.req_a[96 +: 32] = 32'd4;
        bus.req_b[96 +: 32] = 32'd5;
        bus.req = 4'b1010;
        @(negedge clock);
        reset = 1'b0;
        chk("post_rst_rspv", 64'(bus.rsp_valid), 64'd0);
        wait_gnt(g);
        chk("post_rst_gnt1", 64'(g), 64'b0010);
        bus.req[1] = 1'b0;
        wait_rsp(r);
        chk("post_rst_rsp1", 64'(r), 64'b0010);
        chk("post_rst_prod1", bus.rsp_prod, 64'd6);
        wait_gnt(g);
        chk("post_rst_gnt3", 64'(g), 64'b1000);
        bus.req[3] = 1'b0;
        wait_rsp(r);
        chk("post_rst_rsp3", 64'(r), 64'b1000);
        chk("post_rst_prod3", bus.rsp_prod, 64'd20);

        // Fairness with all four requesting; pointer is 0 here.
        mdl_lat = 2;
        for (int i = 0; i < 4; i++) begin
            bus.req_a[i*32 +: 32] = 32'(i + 1);
            bus.req_b[i*32 +: 32] = 32'd10;
        end
        bus.req = 4'b1111;
        wait_gnt(g);
        for (int k = 0; k < 5; k++) begin
            int e;
            logic [3:0] oh;
            e  = k % 4;
            oh = 4'b0001 << e;
            chk($sformatf("fair%0d_gnt", k), 64'(g), 64'(oh));
            bus.req[e] = 1'b0;
            wait_rsp(r);
            chk($sformatf("fair%0d_rsp", k), 64'(r), 64'(oh));
            chk($sformatf("fair%0d_prod", k), bus.rsp_prod, 64'((e + 1) * 10));
            if (k < 4) begin
                bus.req[e] = 1'b1;
                low = m_start ? 0 : 1;
                g = '0;
                for (int n = 0; n < 100; n++) begin
                    @(negedge clock);
                    if (bus.gnt !== 4'b0) begin
                        g = bus.gnt;
                        break;
                    end
                    if (!m_start) low++;
                end
                chk($sformatf("fair%0d_gap", k), 64'(low >= 2), 64'd1);
            end
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/mult_rr_sched.md
Name: mult_rr_sched

Overview:
Round-robin scheduler that shares one multi_vl variable-latency multiplier between N_REQ requesters. It accepts operand pairs, drives the multiplier's start/operand inputs, and waits for valid. It then returns the 64-bit product, measured latency and timeout status to the owning requester. It sits directly in front of the multi_vl instance; the multiplier itself is instantiated by the parent.

Parameters:
N_REQ, 4, number of requesters (2..8)
WIDTH, 32, operand width; product is 2*WIDTH
MAX_LAT, 40, BUSY cycles allowed before a timeout is declared (the multiplier needs up to 33)
CNT_W, 6, latency counter width; must hold MAX_LAT

Ports:
clock  in  1  single clock, rising edge
reset  in  1  asynchronous, active-high reset
req  in  N_REQ  per-requester request level; held until gnt
req_a  in  N_REQ*WIDTH  signed multiplier operand; slice i belongs to requester i
req_b  in  N_REQ*WIDTH  signed multiplicand operand; slice i belongs to requester i
gnt  out  N_REQ  one-hot, one-cycle accept pulse
rsp_valid  out  N_REQ  one-hot, one-cycle response pulse to the owner
rsp_prod  out  2*WIDTH  signed product; valid with rsp_valid
rsp_lat  out  CNT_W  BUSY cycles taken by the operation
rsp_timeout  out  1  qualifies rsp_valid: the operation was abandoned
busy  out  1  high in BUSY and GAP
m_start  out  1  to multi_vl start; held high for the whole operation
m_mlier  out  WIDTH  to multi_vl mlier
m_mcand  out  WIDTH  to multi_vl mcand
m_prodt  in  2*WIDTH  from multi_vl product
m_valid  in  1  from multi_vl valid (level)

Behaviour:
- Reset (async) forces state=IDLE, rr pointer=0, owner=0, lat=0. It also drives every output to 0: gnt, rsp_valid, rsp_prod, rsp_lat, rsp_timeout, busy, m_start, m_mlier, m_mcand.
- Reset mid-operation drops m_start immediately. The in-flight result is discarded and no rsp_valid is issued.

IDLE:
- On an edge where req != 0, pick the first set bit at or after the pointer, wrapping.
- Registered results of that edge:
  - gnt[i]=1 for one cycle
  - owner=i
  - m_mlier/m_mcand = slice i of req_a/req_b
  - m_start=1, busy=1, lat=1
  - state=BUSY
- Operands are sampled only at that edge. The requester drops req after seeing gnt.

BUSY:
- m_start and operands are held stable. req is ignored.
- Each edge with m_valid=0 and lat<MAX_LAT: lat+1.
- Edge with m_valid=1:
  - rsp_prod=m_prodt, rsp_lat=lat, rsp_timeout=0
  - rsp_valid[owner]=1 for one cycle
  - m_start=0
  - pointer=owner+1 mod N_REQ
  - state=GAP
- Edge with m_valid=0 and lat==MAX_LAT: same as the m_valid=1 case, except rsp_prod=0 and rsp_timeout=1.
- m_valid and lat==MAX_LAT on the same edge: valid wins (rsp_timeout=0).

GAP:
- One cycle with m_start=0, which guarantees a fresh start rising edge for the next operation.
- Then state=IDLE and busy=0.

General rules:
- m_valid is ignored outside BUSY.
- rsp_prod, rsp_lat and rsp_timeout hold their values until the next response.
- Turnaround: the m_valid edge, then at least 2 cycles with m_start low, then the next grant.
- Worst-case wait for a continuously requesting client: N_REQ-1 operations.
- rsp_valid is never asserted in the same cycle as gnt to the same requester.

Decomposition:
- Shared package mult_pkg holds:
  - state encoding IDLE=2'd0, BUSY=2'd1, GAP=2'd2
  - constants WIDTH and MAX_LAT defaults
  - product width 2*WIDTH
- One sub-module, rr_pick: combinational round-robin select from (req, pointer), giving a one-hot grant and an index.
- FSM, counter and registers live in mult_rr_sched.

Test Plan:
- Single request, multi_vl attached, req[1]=1, a=3, b=5 -> gnt[1] pulses once; m_start high until valid; rsp_valid[1] pulses with rsp_prod=64'h0F, rsp_timeout=0, rsp_lat equal to the clocks counted from m_start rise to valid.
- Signed product: a=-2, b=7 on requester 0 -> rsp_prod=64'hFFFF_FFFF_FFFF_FFF2; then a=32'h0FFFFFFE, b=32'h0FFFFFFE -> rsp_prod=64'h00FF_FFFF_C000_0004.
- Fairness: req=4'b1111 held, each requester dropping and re-raising after its response -> grant order 0,1,2,3,0; m_start low at least 2 cycles between operations.
- Timeout: stub multiplier with m_valid tied 0 -> rsp_valid[owner] after exactly MAX_LAT=40 BUSY cycles, rsp_timeout=1, rsp_prod=0, rsp_lat=40; the next request is served normally.
- Edge collision: stub asserts m_valid on the edge where lat==MAX_LAT -> rsp_timeout=0 and rsp_prod=m_prodt.
- Reset at BUSY cycle 10 -> m_start=0 without waiting for a clock, all outputs 0, pointer 0; after release, req=4'b1010 grants requester 1 first; no stray rsp_valid.
